// File: rtl/axi_lite_rd_arb_pkg.sv
// axi_lite_rd_arb_pkg: shared types and constants for the AXI-lite read arbiter.
package axi_lite_rd_arb_pkg;
   typedef enum logic {IDLE, ISSUE} state_e;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/axi_lite_rd_order_fifo.sv
// axi_lite_rd_order_fifo: in-order FIFO of requester indices for issued reads.
module axi_lite_rd_order_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0] cnt_q;
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= din_i;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
      end
   assign full_o  = cnt_q == (PW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/axi_lite_read_arbiter.sv
// axi_lite_read_arbiter: round-robin AXI-lite read arbiter with in-order response routing.
// Optional AXI_LITE_RD_ARB_PRIO0_EN gives requester 0 absolute priority.
module axi_lite_read_arbiter
   import axi_lite_rd_arb_pkg::*;
#(
   parameter int NUM_REQ          = 4,
   parameter int AXI_ARADDR_WIDTH = 8,
   parameter int AXI_RDATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING  = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    s_arvalid,
   output logic [NUM_REQ-1:0]                    s_arready,
   input  logic [NUM_REQ*AXI_ARADDR_WIDTH-1:0]   s_araddr,
   input  logic [NUM_REQ*3-1:0]                  s_arprot,
   output logic [NUM_REQ-1:0]                    s_rvalid,
   input  logic [NUM_REQ-1:0]                    s_rready,
   output logic [AXI_RDATA_WIDTH-1:0]            s_rdata,
   output logic [1:0]                            s_rresp,
   output logic                                  m_arvalid,
   input  logic                                  m_arready,
   output logic [AXI_ARADDR_WIDTH-1:0]           m_araddr,
   output logic [2:0]                            m_arprot,
   input  logic                                  m_rvalid,
   output logic                                  m_rready,
   input  logic [AXI_RDATA_WIDTH-1:0]            m_rdata,
   input  logic [1:0]                            m_rresp
);
   localparam int IW = idx_w(NUM_REQ);
   localparam int AW = AXI_ARADDR_WIDTH;
   state_e state_q;
   logic [IW-1:0] grant_q, grant_d, last_q, idx, head;
   logic [AW-1:0] araddr_q;
   logic [2:0] arprot_q;
   logic found, full, empty, push, pop;
   // Rotating search starting just after the last granted requester.
   always_comb begin
      grant_d = '0;
      found   = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(last_q) + k) % NUM_REQ);
         if (!found && s_arvalid[idx]) begin
            grant_d = idx;
            found   = 1'b1;
         end
      end
`ifdef AXI_LITE_RD_ARB_PRIO0_EN
      if (s_arvalid[0]) grant_d = '0;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         last_q   <= IW'(NUM_REQ - 1);
         araddr_q <= '0;
         arprot_q <= '0;
      end else if (state_q == IDLE) begin
         if (|s_arvalid && !full) begin
            state_q  <= ISSUE;
            grant_q  <= grant_d;
            araddr_q <= s_araddr[grant_d*AW +: AW];
            arprot_q <= s_arprot[grant_d*3 +: 3];
         end
      end else if (m_arready) begin
         state_q <= IDLE;
`ifdef AXI_LITE_RD_ARB_PRIO0_EN
         if (grant_q != '0) last_q <= grant_q;
`else
         last_q <= grant_q;
`endif
      end
   assign push      = state_q == ISSUE && m_arready;
   assign m_arvalid = state_q == ISSUE;
   assign m_araddr  = araddr_q;
   assign m_arprot  = arprot_q;
   assign s_arready = push ? NUM_REQ'(1) << grant_q : '0;
   assign m_rready  = s_rready[head] && !empty;
   assign s_rvalid  = (m_rvalid && !empty) ? NUM_REQ'(1) << head : '0;
   assign pop       = m_rvalid && m_rready;
   assign s_rdata   = m_rdata;
   assign s_rresp   = m_rresp;
   axi_lite_rd_order_fifo #(.DEPTH(MAX_OUTSTANDING), .W(IW)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push),
      .din_i  (grant_q),
      .pop_i  (pop),
      .full_o (full),
      .empty_o(empty),
      .head_o (head)
   );
endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// tb_axi_lite_read_arbiter: directed self-checking bench for axi_lite_read_arbiter.
module tb_axi_lite_read_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [3:0] s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_araddr;
   logic [11:0] s_arprot;
   logic [31:0] s_rdata, m_rdata;
   logic [1:0] s_rresp, m_rresp;
   logic m_arvalid, m_arready, m_rvalid, m_rready;
   logic [7:0] m_araddr;
   logic [2:0] m_arprot;
   int checks = 0;
   int errors = 0;
   logic [7:0] addrs [4];
   int order [5];

   always #5 clk = ~clk;

   axi_lite_read_arbiter dut (
      .clk(clk), .rst(rst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      addrs = '{8'h10, 8'h21, 8'h40, 8'h23};
      order = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      s_arvalid = '0;
      s_rready = '0;
      s_araddr = {addrs[3], addrs[2], addrs[1], addrs[0]};
      s_arprot = {3'd3, 3'd2, 3'd1, 3'd0};
      m_arready = 1'b0;
      m_rvalid = 1'b0;
      m_rdata = '0;
      m_rresp = 2'b00;
      #2;
      chk("rst_arvalid", m_arvalid, 0);
      chk("rst_arready", s_arready, 0);
      chk("rst_rvalid", s_rvalid, 0);
      chk("rst_rready", m_rready, 0);
      chk("rst_araddr", m_araddr, 0);
      chk("rst_arprot", m_arprot, 0);
      tick();
      rst = 1'b0;
      // single requester 2
      s_arvalid = 4'b0100;
      m_arready = 1'b1;
      #2;
      chk("t1_arvalid_lat", m_arvalid, 0);
      chk("t1_arready_idle", s_arready, 0);
      tick();
      #2;
      chk("t1_arvalid", m_arvalid, 1);
      chk("t1_araddr", m_araddr, 8'h40);
      chk("t1_arprot", m_arprot, 2);
      chk("t1_arready", s_arready, 4'b0100);
      tick();
      s_arvalid = '0;
      #2;
      chk("t1_arvalid_drop", m_arvalid, 0);
      m_rvalid = 1'b1;
      m_rdata = 32'hDEADBEEF;
      s_rready = 4'b0100;
      #2;
      chk("t1_rvalid", s_rvalid, 4'b0100);
      chk("t1_rdata", s_rdata, 32'hDEADBEEF);
      chk("t1_mrready", m_rready, 1);
      tick();
      m_rvalid = 1'b0;
      #2;
      chk("t1_empty_rready", m_rready, 0);
      // all requesters continuously valid: round robin
      do_reset();
      s_arvalid = 4'hF;
      s_rready = 4'hF;
      m_rvalid = 1'b1;
      m_arready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         #2;
         chk("t2_grant", s_arready, 4'(1) << order[i]);
         chk("t2_araddr", m_araddr, addrs[order[i]]);
         tick();
         #2;
         chk("t2_idle", m_arvalid, 0);
         chk("t2_route", s_rvalid, 4'(1) << order[i]);
      end
      s_arvalid = '0;
      tick();
      m_rvalid = 1'b0;
      #2;
      chk("t2_drained", m_rready, 0);
      // FIFO full back-pressure
      do_reset();
      s_arvalid = 4'hF;
      m_arready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("t3_full_arvalid", m_arvalid, 0);
         chk("t3_full_arready", s_arready, 0);
         tick();
      end
      m_rvalid = 1'b1;
      m_rdata = 32'hA0;
      #2;
      chk("t3_head_rvalid", s_rvalid, 4'b0001);
      chk("t3_head_rready", m_rready, 1);
      tick();
      m_rvalid = 1'b0;
      #2;
      chk("t3_pop_no_grant", m_arvalid, 0);
      tick();
      #2;
      chk("t3_fifth_grant", s_arready, 4'b0001);
      chk("t3_fifth_addr", m_araddr, 8'h10);
      tick();
      s_arvalid = '0;
      // in-order routing across requesters 1 then 3
      do_reset();
      s_arvalid = 4'b0010;
      tick();
      #2;
      chk("t4_grant1", s_arready, 4'b0010);
      tick();
      s_arvalid = 4'b1000;
      tick();
      #2;
      chk("t4_grant3", s_arready, 4'b1000);
      chk("t4_addr3", m_araddr, 8'h23);
      tick();
      s_arvalid = '0;
      m_rvalid = 1'b1;
      m_rdata = 32'h11;
      m_rresp = 2'b10;
      s_rready = 4'b1000;
      #2;
      chk("t4_r1_valid", s_rvalid, 4'b0010);
      chk("t4_r1_blocked", m_rready, 0);
      chk("t4_rresp", s_rresp, 2'b10);
      tick();
      #2;
      chk("t4_r1_held", s_rvalid, 4'b0010);
      s_rready = 4'b1010;
      #2;
      chk("t4_r1_ready", m_rready, 1);
      tick();
      m_rdata = 32'h33;
      m_rresp = 2'b00;
      #2;
      chk("t4_r3_valid", s_rvalid, 4'b1000);
      chk("t4_r3_data", s_rdata, 32'h33);
      chk("t4_r3_ready", m_rready, 1);
      tick();
      // stray rvalid with empty FIFO
      #2;
      chk("t5_stray_rready", m_rready, 0);
      chk("t5_stray_rvalid", s_rvalid, 0);
      tick();
      #2;
      chk("t5_stray_rvalid2", s_rvalid, 0);
      m_rvalid = 1'b0;
      // reset while in ISSUE
      s_arvalid = 4'b0110;
      m_arready = 1'b0;
      tick();
      #2;
      chk("t5_issue", m_arvalid, 1);
      chk("t5_issue_noready", s_arready, 0);
      rst = 1'b1;
      #1;
      chk("t5_async_rst", m_arvalid, 0);
      tick();
      rst = 1'b0;
      s_arvalid = 4'b0011;
      m_arready = 1'b1;
      tick();
      #2;
      chk("t5_fresh_grant", s_arready, 4'b0001);
      chk("t5_fresh_addr", m_araddr, 8'h10);
      tick();
      s_arvalid = '0;
`ifdef AXI_LITE_RD_ARB_PRIO0_EN
      do_reset();
      s_arvalid = 4'b0011;
      s_rready = 4'hF;
      m_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         #2;
         chk("t6_prio0", s_arready, 4'b0001);
         tick();
      end
      s_arvalid = 4'b0010;
      tick();
      #2;
      chk("t6_req1", s_arready, 4'b0010);
      tick();
      s_arvalid = '0;
      m_rvalid = 1'b0;
`endif
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
